stpu_inst_mem: RTL and testbench



---
 rtl/stpu_inst_mem_pkg.sv | 16 +
 rtl/stpu_imem_byte_pack.sv | 55 +++++
 rtl/stpu_inst_mem.sv | 151 +++++++++++++++
 tb/tb_stpu_inst_mem.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stpu_inst_mem_pkg.sv
// Shared types for the instruction memory and its byte-stream loader.
package stpu_inst_mem_pkg;

  localparam int unsigned InstBus = 32;
  localparam int unsigned LdCntW  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StChk,
    StDone,
    StErr
  } ld_state_e;

endpackage

// File: rtl/stpu_imem_byte_pack.sv
// Collects four handshaked bytes into one big-endian word; word_valid pulses for one cycle.
module stpu_imem_byte_pack
  import stpu_inst_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic [InstBus-1:0] word,
  output logic               word_valid
);

  logic [LdCntW-1:0]  cnt_q, cnt_d;
  logic [InstBus-9:0] shift_q, shift_d;
  logic [InstBus-1:0] word_q, word_d;
  logic               valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (byte_valid) begin
      if (cnt_q == '1) begin
        word_d  = {shift_q, byte_data};
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        shift_d = {shift_q[InstBus-17:0], byte_data};
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/stpu_inst_mem.sv
// Loadable instruction memory: holds the core in reset until a byte-streamed image is loaded.
// Define STPU_IMEM_CHECKSUM_EN to require a wrap-around sum trailer after the data words.
module stpu_inst_mem
  import stpu_inst_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned INST_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [INST_W-1:0] rom_data_o,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_data_i,
  output logic              ld_ready_o,
  output logic              cpu_rst_o,
  output logic              ld_done_o,
  output logic              ld_err_o
);

  localparam int unsigned         Depth  = 2 ** ADDR_W;
  localparam logic [INST_W-1:0]   DepthW = INST_W'(1) << ADDR_W;
  localparam logic [ADDR_W:0]     WcntOne = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [INST_W-1:0] rom_data_q;
  logic              mem_we;
  logic              pack_valid;
  logic [INST_W-1:0] pack_word;
  logic [INST_W-1:0] mem [Depth];
  logic              unused_addr;
`ifdef STPU_IMEM_CHECKSUM_EN
  logic [INST_W-1:0] sum_q, sum_d;
`endif

  assign unused_addr = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

  stpu_imem_byte_pack u_byte_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (ld_start_i),
    .byte_valid (ld_valid_i && ld_ready_o),
    .byte_data  (ld_data_i),
    .word       (pack_word),
    .word_valid (pack_valid)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    mem_we  = 1'b0;
`ifdef STPU_IMEM_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (ld_start_i) begin
      // A start in any state restarts the header; a word completing this cycle is dropped.
      state_d = StHdr;
      len_d   = '0;
      wcnt_d  = '0;
`ifdef STPU_IMEM_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else begin
      case (state_q)
        StHdr: begin
          if (pack_valid) begin
            len_d = pack_word[ADDR_W:0];
            if (pack_word == '0) begin
`ifdef STPU_IMEM_CHECKSUM_EN
              state_d = StChk;
`else
              state_d = StDone;
`endif
            end else if (pack_word > DepthW) begin
              state_d = StErr;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          if (pack_valid) begin
            mem_we = 1'b1;
            wcnt_d = wcnt_q + WcntOne;
`ifdef STPU_IMEM_CHECKSUM_EN
            sum_d  = sum_q + pack_word;
            if (wcnt_d == len_q) state_d = StChk;
`else
            if (wcnt_d == len_q) state_d = StDone;
`endif
          end
        end
`ifdef STPU_IMEM_CHECKSUM_EN
        StChk: begin
          if (pack_valid) state_d = (pack_word == sum_q) ? StDone : StErr;
        end
`endif
        default: ;
      endcase
    end
    // Core leaves reset one edge after DONE is entered; a restart reasserts it at once.
    cpu_rst_d = !((state_q == StDone) && (state_d == StDone));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      wcnt_q     <= '0;
      cpu_rst_q  <= 1'b1;
      rom_data_q <= '0;
`ifdef STPU_IMEM_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef STPU_IMEM_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
      if ((state_q == StDone) && rom_ce_i) begin
        rom_data_q <= mem[rom_addr_i[ADDR_W+1:2]];
      end else begin
        rom_data_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wcnt_q[ADDR_W-1:0]] <= pack_word;
  end

`ifdef STPU_IMEM_CHECKSUM_EN
  assign ld_ready_o = (state_q == StHdr) || (state_q == StData) || (state_q == StChk);
`else
  assign ld_ready_o = (state_q == StHdr) || (state_q == StData);
`endif
  assign rom_data_o = rom_data_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign ld_done_o  = (state_q == StDone);
  assign ld_err_o   = (state_q == StErr);

endmodule

// File: tb/tb_stpu_inst_mem.sv
// Bench for stpu_inst_mem: byte-stream loads, error paths, restart and fetch scoreboard.
module tb_stpu_inst_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        cpu_rst;
  logic        ld_done;
  logic        ld_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] img[4];

  stpu_inst_mem #(.ADDR_W(10), .INST_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce),
    .rom_addr_i (rom_addr),
    .rom_data_o (rom_data),
    .ld_start_i (ld_start),
    .ld_valid_i (ld_valid),
    .ld_data_i  (ld_data),
    .ld_ready_o (ld_ready),
    .cpu_rst_o  (cpu_rst),
    .ld_done_o  (ld_done),
    .ld_err_o   (ld_err)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    while (!ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      $display("FAIL send_byte: ld_ready=%0b required 1", ld_ready);
      $fatal(1, "loader never ready");
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  // Waits (bounded) for DONE or ERR, then one more edge so cpu_rst has settled.
  task automatic wait_end();
    int n = 0;
    while (!(ld_done || ld_err) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) $display("FAIL wait_end: done=%0b err=%0b required one set", ld_done, ld_err);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic load_image(input int n);
    logic [31:0] sum = '0;
    start_load();
    send_word(32'(n));
    for (int i = 0; i < n; i++) begin
      send_word(img[i]);
      sum += img[i];
    end
`ifdef STPU_IMEM_CHECKSUM_EN
    send_word(sum);
`endif
    wait_end();
  endtask

  task automatic do_fetch(input logic ce, input logic [31:0] addr, input logic [31:0] exp,
                          input string name);
    logic [31:0] e;
    rom_ce   = ce;
    rom_addr = addr;
    exp_q.push_back(exp);
    @(negedge clk);
    rom_ce = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (rom_data !== e) $display("FAIL fetch %s: got %h required %h", name, rom_data, e);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rom_ce = 1'b0; rom_addr = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (rom_data !== 32'h0) $display("FAIL reset rom_data: got %h required 0", rom_data);
    else n_pass++;
    if (ld_ready !== 1'b0) $display("FAIL reset ld_ready: got %b required 0", ld_ready);
    else n_pass++;
    if (cpu_rst !== 1'b1) $display("FAIL reset cpu_rst: got %b required 1", cpu_rst);
    else n_pass++;
    if (ld_done !== 1'b0) $display("FAIL reset ld_done: got %b required 0", ld_done);
    else n_pass++;
    if (ld_err !== 1'b0) $display("FAIL reset ld_err: got %b required 0", ld_err);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    do_fetch(1'b1, 32'h0, 32'h0, "idle_addr0");
    n_checks++;
    if (cpu_rst !== 1'b1) $display("FAIL idle cpu_rst: got %b required 1", cpu_rst);
    else n_pass++;
  endtask

  task automatic test_load_fetch();
    img[0] = 32'h3C011234;
    img[1] = 32'h34210056;
    load_image(2);
    n_checks += 2;
    if (ld_done !== 1'b1) $display("FAIL load2 ld_done: got %b required 1", ld_done);
    else n_pass++;
    if (cpu_rst !== 1'b0) $display("FAIL load2 cpu_rst: got %b required 0", cpu_rst);
    else n_pass++;
    do_fetch(1'b1, 32'h0, 32'h3C011234, "load2_w0");
    do_fetch(1'b1, 32'h4, 32'h34210056, "load2_w1");
    do_fetch(1'b0, 32'h4, 32'h0, "load2_ce0");
  endtask

  task automatic test_boundary_len();
    start_load();
    n_checks++;
    if (cpu_rst !== 1'b1) $display("FAIL restart cpu_rst: got %b required 1", cpu_rst);
    else n_pass++;
    send_word(32'h00000400);
    repeat (2) @(negedge clk);
    n_checks += 2;
    if (ld_err !== 1'b0) $display("FAIL hdr_depth ld_err: got %b required 0", ld_err);
    else n_pass++;
    if (ld_ready !== 1'b1) $display("FAIL hdr_depth ld_ready: got %b required 1", ld_ready);
    else n_pass++;
  endtask

  task automatic test_err();
    start_load();
    send_word(32'h00000401);
    wait_end();
    n_checks += 3;
    if (ld_err !== 1'b1) $display("FAIL hdr_big ld_err: got %b required 1", ld_err);
    else n_pass++;
    if (cpu_rst !== 1'b1) $display("FAIL hdr_big cpu_rst: got %b required 1", cpu_rst);
    else n_pass++;
    if (ld_done !== 1'b0) $display("FAIL hdr_big ld_done: got %b required 0", ld_done);
    else n_pass++;
    do_fetch(1'b1, 32'h0, 32'h0, "err_fetch");
    start_load();
    n_checks++;
    if (ld_err !== 1'b0) $display("FAIL err_clear ld_err: got %b required 0", ld_err);
    else n_pass++;
    img[0] = 32'hDEADBEEF;
    load_image(1);
    n_checks++;
    if (ld_done !== 1'b1) $display("FAIL err_recover ld_done: got %b required 1", ld_done);
    else n_pass++;
    do_fetch(1'b1, 32'h0, 32'hDEADBEEF, "err_recover_w0");
  endtask

  task automatic test_zero_len();
    load_image(0);
    n_checks += 2;
    if (ld_done !== 1'b1) $display("FAIL zero ld_done: got %b required 1", ld_done);
    else n_pass++;
    if (cpu_rst !== 1'b0) $display("FAIL zero cpu_rst: got %b required 0", cpu_rst);
    else n_pass++;
`ifdef STPU_IMEM_CHECKSUM_EN
    start_load();
    send_word(32'h0);
    send_word(32'h1);
    wait_end();
    n_checks++;
    if (ld_err !== 1'b1) $display("FAIL zero_badsum ld_err: got %b required 1", ld_err);
    else n_pass++;
`endif
  endtask

  task automatic test_restart_wrap();
    start_load();
    send_word(32'h00000003);
    send_byte(8'hAB);
    send_byte(8'hCD);
    n_checks++;
    if (cpu_rst !== 1'b1) $display("FAIL midload cpu_rst: got %b required 1", cpu_rst);
    else n_pass++;
    img[0] = 32'h11223344;
    img[1] = 32'h55667788;
    load_image(2);
    n_checks++;
    if (ld_done !== 1'b1) $display("FAIL restart ld_done: got %b required 1", ld_done);
    else n_pass++;
    do_fetch(1'b1, 32'h0, 32'h11223344, "restart_w0");
    do_fetch(1'b1, 32'h4, 32'h55667788, "restart_w1");
    do_fetch(1'b1, 32'h1000, 32'h11223344, "wrap_1000");
    do_fetch(1'b1, 32'h1007, 32'h55667788, "wrap_1007");
  endtask

`ifdef STPU_IMEM_CHECKSUM_EN
  task automatic test_checksum();
    img[0] = 32'hFFFFFFFF;
    img[1] = 32'h00000002;
    load_image(2);
    n_checks++;
    if (ld_done !== 1'b1) $display("FAIL chk_wrap ld_done: got %b required 1", ld_done);
    else n_pass++;
    start_load();
    send_word(32'h2);
    send_word(32'hFFFFFFFF);
    send_word(32'h00000002);
    send_word(32'h00000002);
    wait_end();
    n_checks++;
    if (ld_err !== 1'b1) $display("FAIL chk_bad ld_err: got %b required 1", ld_err);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_load_fetch();
    test_boundary_len();
    test_err();
    test_zero_len();
    test_restart_wrap();
`ifdef STPU_IMEM_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
